// File: rtl/led_sequencer_pkg.sv
// Shared mode and state encodings for the LED sequencer.
package led_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_SOLID   = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_SOLID,
    ST_BLINK_ON,
    ST_BLINK_OFF,
    ST_RAMP_UP,
    ST_RAMP_DOWN,
    ST_FLASH
  } state_e;

  // First state of a pattern whenever it (re)starts.
  function automatic state_e entry_state(input mode_e m);
    case (m)
      MODE_SOLID:   return ST_SOLID;
      MODE_BLINK:   return ST_BLINK_ON;
      MODE_BREATHE: return ST_RAMP_UP;
      default:      return ST_OFF;
    endcase
  endfunction

endpackage

// File: rtl/led_sequencer_divide_by_n.sv
// Tick prescaler: free-running one-cycle pulse every N clocks.
module divide_by_n #(
  parameter int unsigned N = 1024
) (
  input  logic clk_i,
  input  logic reset_i,
  output logic tick_o
);

  localparam int unsigned W = (N > 2) ? $clog2(N) : 1;

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= W'(N - 1);
    end else if (cnt_q == '0) begin
      cnt_q <= W'(N - 1);
    end else begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/led_sequencer.sv
// PWM status-LED sequencer (OFF/SOLID/BLINK/BREATHE plus event flash).
// Optional gamma mapping of brightness enabled by defining LED_GAMMA_EN.
module led_sequencer
  import led_sequencer_pkg::*;
#(
  parameter int unsigned BITS        = 8,
  parameter int unsigned TICK_DIV    = 1024,
  parameter int unsigned BLINK_TICKS = 128,
  parameter int unsigned HOLD_TICKS  = 64
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            cfg_valid_i,
  input  logic [1:0]      cfg_mode_i,
  input  logic [BITS-1:0] cfg_level_i,
  output logic            cfg_ready_o,
  input  logic            event_i,
  output logic [BITS-1:0] bright_o,
  output logic            led_o,
  output logic            busy_o
);

  localparam int unsigned CNT_MAX = (BLINK_TICKS > HOLD_TICKS) ? BLINK_TICKS : HOLD_TICKS;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  state_e          state_q, state_d;
  mode_e           mode_q, mode_d;
  logic [BITS-1:0] level_q, level_d;
  logic [BITS-1:0] raw_q, raw_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ev_q, ev_prev_q, busy_q, ready_q;
  logic [BITS-1:0] pwm_q;
  logic [BITS-1:0] bright;
  logic            tick, accept, ev_rise;

  divide_by_n #(.N(TICK_DIV)) u_tick (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .tick_o  (tick)
  );

  function automatic logic [BITS-1:0] entry_raw(input mode_e m, input logic [BITS-1:0] lvl);
    return (m == MODE_SOLID || m == MODE_BLINK) ? lvl : '0;
  endfunction

  assign accept  = cfg_valid_i & ready_q;
  assign ev_rise = ev_q & ~ev_prev_q;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    level_d = level_q;
    raw_d   = raw_q;
    cnt_d   = cnt_q;
    if (accept) begin
      mode_d  = mode_e'(cfg_mode_i);
      level_d = cfg_level_i;
    end
    // An event edge wins over a simultaneous accept; the accepted mode runs after the flash.
    if (ev_rise) begin
      state_d = ST_FLASH;
      raw_d   = '1;
      cnt_d   = '0;
    end else if (accept) begin
      state_d = entry_state(mode_d);
      raw_d   = entry_raw(mode_d, level_d);
      cnt_d   = '0;
    end else if (tick) begin
      case (state_q)
        ST_BLINK_ON, ST_BLINK_OFF: begin
          if (cnt_q == CW'(BLINK_TICKS - 1)) begin
            cnt_d   = '0;
            state_d = (state_q == ST_BLINK_ON) ? ST_BLINK_OFF : ST_BLINK_ON;
            raw_d   = (state_q == ST_BLINK_ON) ? '0 : level_q;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_RAMP_UP: begin
          if (raw_q == level_q) begin
            state_d = ST_RAMP_DOWN;
          end else begin
            raw_d = raw_q + BITS'(1);
            if (raw_q + BITS'(1) == level_q) state_d = ST_RAMP_DOWN;
          end
        end
        ST_RAMP_DOWN: begin
          if (raw_q == '0) begin
            state_d = ST_RAMP_UP;
          end else begin
            raw_d = raw_q - BITS'(1);
            if (raw_q == BITS'(1)) state_d = ST_RAMP_UP;
          end
        end
        ST_FLASH: begin
          if (cnt_q == CW'(HOLD_TICKS - 1)) begin
            cnt_d   = '0;
            state_d = entry_state(mode_q);
            raw_d   = entry_raw(mode_q, level_q);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_OFF;
      mode_q    <= MODE_OFF;
      level_q   <= '0;
      raw_q     <= '0;
      cnt_q     <= '0;
      ev_q      <= 1'b0;
      ev_prev_q <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
      pwm_q     <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      level_q   <= level_d;
      raw_q     <= raw_d;
      cnt_q     <= cnt_d;
      ev_q      <= event_i;
      ev_prev_q <= ev_q;
      busy_q    <= (state_d == ST_FLASH);
      ready_q   <= (state_d != ST_FLASH);
      pwm_q     <= pwm_q + BITS'(1);
    end
  end

`ifdef LED_GAMMA_EN
  logic [2*BITS-1:0] raw_w, sq;
  logic [BITS-1:0]   bright_q;
  assign raw_w = {{BITS{1'b0}}, raw_q};
  assign sq    = raw_w * (raw_w + (2*BITS)'(1));
  always_ff @(posedge clk_i) begin
    if (reset_i) bright_q <= '0;
    else         bright_q <= sq[2*BITS-1:BITS];
  end
  assign bright = bright_q;
`else
  assign bright = raw_q;
`endif

  assign bright_o    = bright;
  assign led_o       = (pwm_q < bright);
  assign busy_o      = busy_q;
  assign cfg_ready_o = ready_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Scoreboard bench for led_sequencer: a tick-level pattern model predicts every cycle.
module tb_led_sequencer;

  localparam int TD = 4, BT = 2, HT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic [1:0] cfg_mode = 2'd0;
  logic [7:0] cfg_level = 8'd0;
  logic       ev = 1'b0;
  logic       cfg_ready, led, busy;
  logic [7:0] bright;

  led_sequencer #(.BITS(8), .TICK_DIV(TD), .BLINK_TICKS(BT), .HOLD_TICKS(HT)) dut (
    .clk_i       (clk),
    .reset_i     (rst),
    .cfg_valid_i (cfg_valid),
    .cfg_mode_i  (cfg_mode),
    .cfg_level_i (cfg_level),
    .cfg_ready_o (cfg_ready),
    .event_i     (ev),
    .bright_o    (bright),
    .led_o       (led),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   bright;
    logic led;
    logic busy;
    logic ready;
    int   cyc;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   started = 0;

  function automatic int pattern(input int m, input int l, input int p);
    int ph;
    case (m)
      1: return l;
      2: return ((p / BT) % 2 == 0) ? l : 0;
      3: begin
        if (l == 0) return 0;
        ph = p % (2 * l);
        return (ph <= l) ? ph : 2 * l - ph;
      end
      default: return 0;
    endcase
  endfunction

  function automatic int gamma(input int r);
    return (r * (r + 1)) >> 8;
  endfunction

  // Reference model: pattern position counted in ticks, flash as a tick countdown.
  initial begin
    int  cyc, mode, level, p, held, raw, bexp, ev1, ev2, absc;
    bit  flash, tick, rise, acc;
    exp_t e;
    absc = 0;
    forever begin
      @(posedge clk);
      absc++;
      if (rst) begin
        cyc = 0; mode = 0; level = 0; p = 0; held = 0; flash = 0;
        ev1 = 0; ev2 = 0; raw = 0; bexp = 0;
        started = 1;
      end else if (started) begin
        tick = (cyc % TD == TD - 1);
        rise = (ev1 == 1) && (ev2 == 0);
        acc  = cfg_valid && !flash;
        if (acc) begin
          mode = cfg_mode; level = cfg_level;
        end
`ifdef LED_GAMMA_EN
        bexp = gamma(raw);
`endif
        if (rise) begin
          flash = 1; held = 0; p = 0;
        end else if (acc) begin
          p = 0;
        end else if (tick) begin
          if (flash) begin
            held++;
            if (held == HT) begin
              flash = 0; p = 0;
            end
          end else begin
            p++;
          end
        end
        ev2 = ev1; ev1 = ev;
        cyc++;
        raw = flash ? 255 : pattern(mode, level, p);
`ifndef LED_GAMMA_EN
        bexp = raw;
`endif
      end
      if (started) begin
        e.bright = bexp;
        e.led    = ((cyc % 256) < bexp);
        e.busy   = flash;
        e.ready  = !flash;
        e.cyc    = absc;
        q.push_back(e);
      end
    end
  end

  // Monitor: pops one expectation per cycle and compares away from the clock edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (started) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard_empty: got no expectation, required one per cycle");
        end else begin
          e = q.pop_front();
          if (int'(bright) != e.bright) begin
            n_fail++;
            $display("FAIL bright cyc=%0d: got %0d required %0d", e.cyc, bright, e.bright);
          end
          n_tests++;
          if (led !== e.led) begin
            n_fail++;
            $display("FAIL led cyc=%0d: got %b required %b", e.cyc, led, e.led);
          end
          n_tests++;
          if (busy !== e.busy) begin
            n_fail++;
            $display("FAIL busy cyc=%0d: got %b required %b", e.cyc, busy, e.busy);
          end
          n_tests++;
          if (cfg_ready !== e.ready) begin
            n_fail++;
            $display("FAIL cfg_ready cyc=%0d: got %b required %b", e.cyc, cfg_ready, e.ready);
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg(input int m, input int l);
    cfg_valid = 1'b1; cfg_mode = 2'(m); cfg_level = 8'(l);
    step(1);
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_event(input int width);
    ev = 1'b1;
    step(width);
    ev = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(2);
    cfg(1, 8'h40);   step(520);
    cfg(2, 8'h80);   step(60);
    cfg(3, 3);       step(80);
    cfg(3, 0);       step(20);
    cfg(3, 3);       step(10);
    pulse_event(2);
    cfg_valid = 1'b1; cfg_mode = 2'd1; cfg_level = 8'h22;
    step(6);
    cfg_valid = 1'b0;
    step(30);
    pulse_event(1);  step(6);
    pulse_event(1);  step(30);
    ev = 1'b1;       step(1);
    cfg(1, 8'h10);
    ev = 1'b0;       step(40);
    pulse_event(1);  step(5);
    rst = 1'b1;      step(1);
    rst = 1'b0;      step(10);
    cfg(1, 8'h80);   step(10);
    cfg(1, 8'hFF);   step(10);
    cfg(1, 8'h01);   step(10);
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 14) == 0) ev = ~ev;
      cfg_valid = ($urandom_range(0, 19) == 0);
      cfg_mode  = 2'($urandom_range(0, 3));
      cfg_level = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 5)) : 8'($urandom_range(0, 255));
      step(1);
    end
    rst = 1'b0; cfg_valid = 1'b0; ev = 1'b0;
    step(20);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
